// File: rtl/ula_pkg.sv
// ula_pkg
// Shared definitions for the ALU dispatcher: data/register geometry,
// opcode encodings and the dispatcher state type.
package ula_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

endpackage

// File: rtl/ula_despacho_banco_registros.sv
// banco_registros
// 8 x 8-bit register file with two combinational read ports and one
// synchronous write port. r0 always reads zero and ignores writes.
// Ports:
//   clk, clr           clock, synchronous active-high clear of all registers
//   we, waddr, wdata   write port (takes effect at the rising edge)
//   raddr_a, rdata_a   read port A
//   raddr_b, rdata_b   read port B
module banco_registros
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // r0 is forced to zero on the read side so it never depends on storage
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/ula_despacho.sv
// ula_despacho
// Single-issue dispatcher: accepts one instruction, reads its operands
// from the internal register bank, starts an external ALU, waits ALU_LAT
// cycles for the result and writes it back before accepting the next one.
// Optional feature macro: ULA_DESPACHO_LI_EN enables op 110 as load
// immediate ({2'b00, rs, rt} -> rd, ALU bypassed). Without it op 110 is
// illegal like op 111 (sets sticky err, no writeback).
// Ports:
//   clk, clr                    clock, synchronous active-high reset
//   instr_valid/instr_ready     instruction handshake
//   instr_op/rd/rs/rt           opcode and register fields
//   alu_op/alu_a/alu_b/alu_start  ALU request (start is a one-cycle pulse)
//   alu_res                     ALU result, valid ALU_LAT cycles after start
//   wb_valid/wb_addr/wb_data    writeback pulse
//   err                         sticky illegal-opcode flag
module ula_despacho
  import ula_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam logic [2:0] LAST = 3'(ALU_LAT - 1);

  estado_t           state, state_nx;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              legal, is_li;

`ifdef ULA_DESPACHO_LI_EN
  assign is_li = (op_q == OP_LI);
  assign legal = (op_q != OP_RSV);
`else
  assign is_li = 1'b0;
  assign legal = (op_q != OP_RSV) && (op_q != OP_LI);
`endif

  banco_registros u_banco (
    .clk     (clk),
    .clr     (clr),
    .we      (state == ESCRITA),
    .waddr   (rd_q),
    .wdata   (res_q),
    .raddr_a (rs_q),
    .raddr_b (rt_q),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // State register plus the per-state datapath registers: instruction
  // fields latched on accept, latency counter, captured result, err flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= OCIOSO;
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        OCIOSO: begin
          if (instr_valid) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            rs_q <= instr_rs;
            rt_q <= instr_rt;
          end
        end
        LEITURA: begin
          cnt <= '0;
          if (!legal)     err   <= 1'b1;
          else if (is_li) res_q <= {2'b00, rs_q, rt_q};
        end
        EXECUTA: begin
          // result is sampled on the last latency cycle only
          if (cnt == LAST) begin
            res_q <= alu_res;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs. ALU operands are driven straight from the
  // register bank; they stay stable in EXECUTA because nothing is written
  // until ESCRITA.
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    alu_start   = 1'b0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    case (state)
      OCIOSO: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = LEITURA;
      end
      LEITURA: begin
        if (!legal) begin
          state_nx = OCIOSO;
        end else if (is_li) begin
          state_nx = ESCRITA;
        end else begin
          alu_start = 1'b1;
          alu_op    = op_q;
          alu_a     = rdata_a;
          alu_b     = rdata_b;
          state_nx  = EXECUTA;
        end
      end
      EXECUTA: begin
        alu_op = op_q;
        alu_a  = rdata_a;
        alu_b  = rdata_b;
        if (cnt == LAST) state_nx = ESCRITA;
      end
      ESCRITA: begin
        wb_valid = 1'b1;
        wb_addr  = rd_q;
        wb_data  = res_q;
        state_nx = OCIOSO;
      end
      default: state_nx = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_ula_despacho.sv
// tb_ula_despacho
// Bench for ula_despacho: a table of instructions with hand-derived
// writeback values, a writeback scoreboard, a behavioural ALU with the
// configured latency, plus sequences for back-to-back issue and a clear
// in the middle of a long-latency operation (second instance, ALU_LAT=3).
module tb_ula_despacho;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       wb;
    logic [7:0] data;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr, clr3;
  logic       instr_valid, instr_ready, valid3, ready3;
  logic [2:0] instr_op, instr_rd, instr_rs, instr_rt;
  logic [2:0] op3, rd3, rs3, rt3;
  logic [2:0] alu_op, alu_op3;
  logic [7:0] alu_a, alu_b, alu_res, alu_a3, alu_b3, alu_res3;
  logic       alu_start, alu_start3;
  logic       wb_valid, wb_valid3;
  logic [2:0] wb_addr, wb_addr3;
  logic [7:0] wb_data, wb_data3;
  logic       err, err3;

  int   total = 0;
  int   bad   = 0;
  logic errExp = 1'b0;
  exp_t sbQ[$];
  vec_t vecs[$];
  logic [7:0] p3 [3];

  always #5 clk = ~clk;

  ula_despacho #(.ALU_LAT(1)) dut (
    .clk(clk), .clr(clr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_res(alu_res), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err)
  );

  ula_despacho #(.ALU_LAT(3)) dut3 (
    .clk(clk), .clr(clr3), .instr_valid(valid3), .instr_ready(ready3),
    .instr_op(op3), .instr_rd(rd3), .instr_rs(rs3), .instr_rt(rt3),
    .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_start(alu_start3),
    .alu_res(alu_res3), .wb_valid(wb_valid3), .wb_addr(wb_addr3), .wb_data(wb_data3),
    .err(err3)
  );

  function automatic logic [7:0] aluModel(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b101:  return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ALUs: result appears exactly ALU_LAT cycles after start
  always @(posedge clk) alu_res <= alu_start ? aluModel(alu_op, alu_a, alu_b) : 8'h00;

  always @(posedge clk) begin
    p3[0] <= alu_start3 ? aluModel(alu_op3, alu_a3, alu_b3) : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_res3 = p3[2];

  task automatic checkOutput(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Writeback scoreboard for the ALU_LAT=1 instance
  always @(negedge clk) begin
    if (wb_valid) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL wb_unexpected: got addr %0h data %0h want none", wb_addr, wb_data);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("wb_addr", int'(wb_addr), int'(e.addr));
        checkOutput("wb_data", int'(wb_data), int'(e.data));
      end
    end
  end

  // Issues one instruction and checks its cycle-by-cycle timing relative
  // to the accept edge (cycle 1 = first cycle after the accept edge).
  task automatic applyStimulus(input vec_t v);
    int   startCnt = 0, startFirst = 0, wbFirst = 0, readyFirst = 0;
    logic isLi, isIll, rdy = 1'b0;
`ifdef ULA_DESPACHO_LI_EN
    isLi  = (v.op == 3'b110);
    isIll = (v.op == 3'b111);
`else
    isLi  = 1'b0;
    isIll = (v.op == 3'b111) || (v.op == 3'b110);
`endif
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (instr_ready) begin rdy = 1'b1; break; end
    end
    if (!rdy) begin
      checkOutput({v.name, "_ready_timeout"}, 0, 1);
      return;
    end
    instr_valid = 1'b1;
    instr_op = v.op; instr_rd = v.rd; instr_rs = v.rs; instr_rt = v.rt;
    if (v.wb) sbQ.push_back('{addr: v.rd, data: v.data});
    if (isIll) errExp = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rd = 3'($urandom);
    instr_rs = 3'($urandom); instr_rt = 3'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (alu_start) begin startCnt++; if (startFirst == 0) startFirst = k; end
      if (wb_valid && wbFirst == 0) wbFirst = k;
      if (instr_ready && readyFirst == 0) readyFirst = k;
    end
    checkOutput({v.name, "_start_cnt"}, startCnt, (isIll || isLi) ? 0 : 1);
    checkOutput({v.name, "_start_cyc"}, startFirst, (isIll || isLi) ? 0 : 1);
    checkOutput({v.name, "_wb_cyc"}, wbFirst, isIll ? 0 : (isLi ? 2 : 3));
    checkOutput({v.name, "_ready_cyc"}, readyFirst, isIll ? 2 : (isLi ? 3 : 4));
    checkOutput({v.name, "_err"}, int'(err), int'(errExp));
  endtask

  task automatic issue3(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt);
    logic rdy = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (ready3) begin rdy = 1'b1; break; end
    end
    checkOutput("lat3_ready_wait", int'(rdy), 1);
    valid3 = 1'b1; op3 = op; rd3 = rd; rs3 = rs; rt3 = rt;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
  endtask

  task automatic waitWb3(output int cyc, output logic [7:0] d);
    cyc = 0;
    d   = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wb_valid3 && cyc == 0) begin cyc = k; d = wb_data3; end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         cyc;
    logic [7:0] d;
    logic [11:0] mask;

    vecs.push_back('{"add_r1_r0_r0", 3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 8'h00});
    vecs.push_back('{"not_r1",       3'b100, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF});
    vecs.push_back('{"add_r2",       3'b000, 3'd2, 3'd1, 3'd1, 1'b1, 8'hFE});
    vecs.push_back('{"sub_r3",       3'b001, 3'd3, 3'd1, 3'd2, 1'b1, 8'h01});
    vecs.push_back('{"add_r4",       3'b000, 3'd4, 3'd3, 3'd3, 1'b1, 8'h02});
    vecs.push_back('{"or_r5",        3'b011, 3'd5, 3'd4, 3'd3, 1'b1, 8'h03});
    vecs.push_back('{"and_r5",       3'b010, 3'd5, 3'd5, 3'd2, 1'b1, 8'h02});
    vecs.push_back('{"slt_true",     3'b101, 3'd6, 3'd3, 3'd4, 1'b1, 8'h01});
    vecs.push_back('{"slt_false",    3'b101, 3'd7, 3'd4, 3'd3, 1'b1, 8'h00});
    vecs.push_back('{"add_wrap",     3'b000, 3'd7, 3'd2, 3'd2, 1'b1, 8'hFC});
    vecs.push_back('{"sub_wrap",     3'b001, 3'd6, 3'd3, 3'd2, 1'b1, 8'h03});
    vecs.push_back('{"not_to_r0",    3'b100, 3'd0, 3'd3, 3'd0, 1'b1, 8'hFE});
    vecs.push_back('{"r0_reads_0",   3'b000, 3'd6, 3'd0, 3'd0, 1'b1, 8'h00});
`ifdef ULA_DESPACHO_LI_EN
    vecs.push_back('{"li_r1_2a",     3'b110, 3'd1, 3'd5, 3'd2, 1'b1, 8'h2A});
    vecs.push_back('{"li_r2_05",     3'b110, 3'd2, 3'd0, 3'd5, 1'b1, 8'h05});
    vecs.push_back('{"li_sub",       3'b001, 3'd3, 3'd1, 3'd2, 1'b1, 8'h25});
    vecs.push_back('{"li_slt_t",     3'b101, 3'd4, 3'd2, 3'd1, 1'b1, 8'h01});
    vecs.push_back('{"li_slt_f",     3'b101, 3'd4, 3'd1, 3'd2, 1'b1, 8'h00});
    vecs.push_back('{"li_r1_3f",     3'b110, 3'd1, 3'd7, 3'd7, 1'b1, 8'h3F});
    vecs.push_back('{"li_add_7e",    3'b000, 3'd2, 3'd1, 3'd1, 1'b1, 8'h7E});
    vecs.push_back('{"li_add_fc",    3'b000, 3'd3, 3'd2, 3'd2, 1'b1, 8'hFC});
    vecs.push_back('{"li_add_f8",    3'b000, 3'd4, 3'd3, 3'd3, 1'b1, 8'hF8});
`endif
    vecs.push_back('{"op_reserved",  3'b111, 3'd5, 3'd1, 3'd1, 1'b0, 8'h00});
`ifndef ULA_DESPACHO_LI_EN
    vecs.push_back('{"op_li_off",    3'b110, 3'd5, 3'd7, 3'd7, 1'b0, 8'h00});
`endif
    vecs.push_back('{"r5_kept",      3'b011, 3'd5, 3'd5, 3'd0, 1'b1, 8'h02});

    clr = 1'b1; clr3 = 1'b1;
    instr_valid = 1'b0; valid3 = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs = '0; instr_rt = '0;
    op3 = '0; rd3 = '0; rs3 = '0; rt3 = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0; clr3 = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", int'(instr_ready), 1);
    checkOutput("reset_outputs",
                int'({alu_start, wb_valid, err, alu_op, alu_a, alu_b, wb_addr, wb_data}), 0);

    $display("[TB] table of %0d instructions", vecs.size());
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // instr_valid held high: accepts only on every fourth cycle
    for (int i = 0; i < 3; i++) sbQ.push_back('{addr: 3'd1, data: 8'h00});
    instr_valid = 1'b1;
    instr_op = 3'b000; instr_rd = 3'd1; instr_rs = 3'd0; instr_rt = 3'd0;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      mask[i] = instr_ready;
      if (i == 11) instr_valid = 1'b0;
    end
    checkOutput("b2b_ready_mask", int'(mask), 12'h111);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", int'(err), int'(errExp));
    checkOutput("sb_drained", sbQ.size(), 0);

    // clear resets err and the register contents
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    errExp = 1'b0;
    @(negedge clk);
    checkOutput("clr_err", int'(err), 0);
    checkOutput("clr_ready", int'(instr_ready), 1);
    applyStimulus('{"r7_cleared", 3'b011, 3'd7, 3'd7, 3'd7, 1'b1, 8'h00});

    // ALU_LAT=3 instance: normal op, then clear during EXECUTA
    issue3(3'b100, 3'd1, 3'd0, 3'd0);
    waitWb3(cyc, d);
    checkOutput("lat3_wb_cyc", cyc, 5);
    checkOutput("lat3_wb_data", int'(d), 8'hFF);
    issue3(3'b000, 3'd2, 3'd1, 3'd1);
    @(negedge clk);
    checkOutput("lat3_start", int'(alu_start3), 1);
    checkOutput("lat3_alu_a", int'(alu_a3), 8'hFF);
    @(negedge clk);
    clr3 = 1'b1;
    @(posedge clk);
    #1;
    clr3 = 1'b0;
    @(negedge clk);
    checkOutput("lat3_clr_ready", int'(ready3), 1);
    checkOutput("lat3_clr_err", int'(err3), 0);
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (wb_valid3) cyc++;
    end
    checkOutput("lat3_no_wb", cyc, 0);
    issue3(3'b000, 3'd3, 3'd1, 3'd1);
    waitWb3(cyc, d);
    checkOutput("lat3_post_clr_cyc", cyc, 5);
    checkOutput("lat3_post_clr_data", int'(d), 8'h00);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_despacho.md
ULA_DESPACHO -- requirements
Module: ula_despacho

Interface
REQ-001 Parameter ALU_LAT, default 1, cycles from alu_start to alu_res valid (legal 1..4).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  dispatcher can accept; transfer when valid & ready.
REQ-006 instr_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 not, 101 slt, 110 li, 111 reserved.
REQ-007 instr_rd / instr_rs / instr_rt  input  3 each  destination / source A / source B register.
REQ-008 alu_op  output  3  operation to ALU, same encoding as instr_op.
REQ-009 alu_a / alu_b  output  8 each  ALU operands.
REQ-010 alu_start  output  1  one-cycle pulse, operands valid.
REQ-011 alu_res  input  8  ALU result, valid ALU_LAT cycles after alu_start.
REQ-012 wb_valid  output  1  one-cycle writeback pulse.
REQ-013 wb_addr  output  3;  wb_data  output  8  writeback register and value.
REQ-014 err  output  1  sticky illegal-opcode flag.

Function
REQ-015 Internal bank of 8 x 8-bit registers; r0 always reads 0x00, writes to r0 discarded (wb_valid still pulses).
REQ-016 FSM states OCIOSO, LEITURA, EXECUTA, ESCRITA; instr_ready = 1 only in OCIOSO.
REQ-017 OCIOSO -> LEITURA on transfer; op, rd, rs, rt latched at that edge; instr_* ignored thereafter until OCIOSO.
REQ-018 LEITURA (1 cycle): alu_a = R[rs], alu_b = R[rt], alu_op = op, alu_start = 1; -> EXECUTA.
REQ-019 EXECUTA: alu_a/alu_b/alu_op held stable, wait counter counts ALU_LAT cycles, alu_res captured at end of last; -> ESCRITA.
REQ-020 ESCRITA (1 cycle): wb_valid = 1, wb_addr = rd, wb_data = captured result, R[rd] updated at end of cycle; -> OCIOSO.
REQ-021 ALU_LAT=1 timing: accept edge N, alu_start in cycle N+1, wb_valid in cycle N+3, instr_ready high again in cycle N+4.
REQ-022 Arithmetic and wrap-around are the ALU's; dispatcher passes 8-bit values unmodified, no carry/overflow tracking.
REQ-023 Op 111 (and 110 when li compiled out): no ALU start, no writeback, err set to 1 at end of LEITURA, -> OCIOSO.
REQ-024 Back-to-back dependent instructions need no forwarding: writeback completes before next accept.

Reset
REQ-025 clr=1 at a rising edge: state OCIOSO, all registers 0x00, err 0, counter 0, all outputs 0 except instr_ready 1 in the following cycle.
REQ-026 clr mid-operation discards the in-flight instruction; no wb_valid for it, late alu_res ignored.

Configuration
REQ-027 Macro ULA_DESPACHO_LI_EN defined: op 110 = load immediate, value {2'b00, rs, rt} written to rd, ALU bypassed, LEITURA -> ESCRITA directly (wb_valid in cycle N+2), alu_start stays 0.
REQ-028 Macro undefined: op 110 treated as illegal per REQ-023.

Structure
REQ-029 Package ula_pkg holds opcode constants, state enum, data width (8), register count (8) and address width (3).
REQ-030 Sub-module banco_registros: 8x8, two combinational read ports, one synchronous write port, r0 hardwired zero, cleared by clr.

Verification
REQ-031 After clr, add r1,r0,r0 -> wb_valid in cycle N+3, wb_addr 1, wb_data 0x00, alu_start exactly one cycle.
REQ-032 (LI_EN) li r1,0x2A; li r2,0x05; sub r3,r1,r2 -> wb_data 0x25; slt r4,r2,r1 -> 0x01; slt r4,r1,r2 -> 0x00.
REQ-033 (LI_EN) li r1,0x3F; add r2,r1,r1 -> 0x7E; add r3,r2,r2 -> 0xFC; add r4,r3,r3 -> 0xF8 (wrap).
REQ-034 instr_valid held high continuously -> accepts only every 4 cycles (ALU_LAT=1), instr_ready low in LEITURA/EXECUTA/ESCRITA.
REQ-035 Op 111, then op 110 without LI_EN -> err=1, no wb_valid, err stays 1 until clr; not r0,r1 -> wb pulses, r0 still reads 0x00.
REQ-036 clr asserted during EXECUTA with ALU_LAT=3 -> no wb_valid, all registers 0x00, instr_ready=1 next cycle.
